tcb_batch_sequencer: RTL and testbench
======================================

Name: tcb_batch_sequencer

Overview:
- Batch controller for the 121-64-10 TCB MNIST inference pipeline.
- Fetches images and labels from a synchronous image/label memory and launches them one at a time into the network top.
- Waits for each prediction, compares it with the label and accumulates a correct-prediction count over a run-time batch length.
- Sits between the test/image memory and the network top; only one image is ever in flight.

Parameters:
IMG_W, 968, image word width (121 pixels x 8 bits)
ADDR_W, 10, image memory address width
PRED_W, 32, width of network prediction bus
TIMEOUT, 4096, watchdog limit in cycles per image (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a batch when idle, ignored otherwise
num_img  in  ADDR_W+1  batch length, sampled on an accepted start
mem_rd  out  1  image memory read strobe
mem_addr  out  ADDR_W  image memory address
mem_img  in  IMG_W  image data; valid exactly 1 cycle after mem_rd
mem_label  in  4  label digit; valid with mem_img
net_img  out  IMG_W  image to network (img_source)
net_valid  out  1  one-cycle launch pulse to network (valid_top)
net_ready  in  1  one-cycle completion pulse from network (ready_top)
net_number  in  PRED_W  prediction; valid when net_ready=1
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at batch end
img_idx  out  ADDR_W+1  number of images completed in the current batch
correct_cnt  out  ADDR_W+1  running correct-prediction count
last_pred  out  4  low 4 bits of the latest prediction
err_timeout  out  1  sticky watchdog flag (optional feature; tied 0 when compiled out)

Behaviour:
- Reset value of every output is 0.
  - This includes net_img, mem_addr, the counters, last_pred and err_timeout.
  - The FSM resets to IDLE.
- The reset is asynchronous, so asserting rst mid-batch aborts immediately.
  - No done pulse is produced.
  - A net_ready arriving after release is ignored while in IDLE.
- FSM states and transitions:
  - IDLE: on start with num_img!=0:
    - latch num_img
    - clear img_idx, correct_cnt, last_pred
    - set busy=1 and mem_addr=0
    - go to FETCH.
  - IDLE, start with num_img==0: set busy=0 and pulse done for 1 cycle; counters are cleared.
  - FETCH: assert mem_rd for 1 cycle at mem_addr, then go to WAIT_DATA.
  - WAIT_DATA: register mem_img into net_img and mem_label into the label register, then go to LAUNCH.
  - LAUNCH: net_valid=1 for exactly 1 cycle with net_img stable, then go to WAIT_NET.
    - net_img is held constant until the next WAIT_DATA.
  - WAIT_NET: wait for net_ready.
    - On net_ready, capture net_number[3:0] into last_pred.
    - If net_number == zero-extended label, increment correct_cnt.
    - Increment img_idx and go to CHECK.
    - A net_ready in the same cycle as the LAUNCH pulse is impossible by design and is not handled.
  - CHECK: if img_idx == latched num_img, go to DONE; else increment mem_addr and go to FETCH.
  - DONE: pulse done for 1 cycle, drop busy, return to IDLE.
    - img_idx, correct_cnt and last_pred hold their values until the next accepted start.
- Per-image overhead: 4 controller cycles plus network latency.
  - Start to first net_valid: 3 cycles (FETCH, WAIT_DATA, LAUNCH).
  - Last net_ready to done: 2 cycles.
- net_ready outside WAIT_NET is ignored. start while busy is ignored.
- Counters:
  - ADDR_W+1 bits, unsigned.
  - num_img up to 2^ADDR_W.
  - mem_addr never wraps within a batch because img_idx reaches num_img first.
- Equality compare uses the full PRED_W prediction, so a prediction above 9 is always counted incorrect.

Optional Feature:
- Macro: TCB_SEQ_WATCHDOG_EN.
- Defined: a cycle counter clears on entry to WAIT_NET.
  - If TIMEOUT cycles elapse without net_ready:
    - set err_timeout (sticky until next accepted start or reset)
    - count the image as incorrect, with last_pred unchanged
    - increment img_idx and go to CHECK.
  - The batch therefore always completes.
- Not defined: no counter logic; err_timeout tied 0; WAIT_NET waits indefinitely.

Test Plan:
- Reset then idle -> all outputs 0; start with num_img=0 -> done pulse 1 cycle after start, busy stays 0, correct_cnt=0.
- num_img=3, network model answers label each time after 20 cycles -> 3 net_valid pulses at mem_addr 0,1,2; done; correct_cnt=3, img_idx=3; first net_valid 3 cycles after start.
- num_img=4, model returns label for images 0,2 and (label+1)%10 for 1,3 -> correct_cnt=2, last_pred = image 3 label+1.
- Mid-batch start pulse and spurious net_ready during FETCH -> both ignored; counts unchanged vs clean run.
- rst low during WAIT_NET of image 2 -> outputs 0 asynchronously; later start with num_img=1 runs normally, correct_cnt from 0.
- With TCB_SEQ_WATCHDOG_EN, TIMEOUT=64, model never responds on image 1 of 2 -> err_timeout=1 at cycle 64 of WAIT_NET, batch completes, img_idx=2, correct_cnt=1.

Source files
------------

// File: rtl/tcb_batch_sequencer.sv
// tcb_batch_sequencer
//   Batch controller for the 121-64-10 TCB MNIST inference pipeline. It reads
//   one image and label at a time from a synchronous image/label memory and
//   launches the image into the network top. It then waits for the prediction
//   and scores it against the label. A correct-prediction count is kept over a
//   batch whose length is set at run time. Only one image is ever in flight.
//
//   Optional build macro: TCB_SEQ_WATCHDOG_EN
//     When defined, a per-image watchdog bounds the wait for the network.
//     After TIMEOUT cycles with no ready the image is scored as incorrect and
//     err_timeout is set. When undefined, err_timeout is tied low and the
//     sequencer waits for the network indefinitely.
//
//   Ports
//     clk, rst          clock, asynchronous active-low reset
//     start, num_img    batch start pulse (accepted only when idle) and length
//     mem_rd, mem_addr  image memory read strobe / address
//     mem_img, mem_label image word and label, valid one cycle after mem_rd
//     net_img, net_valid image to network and one-cycle launch pulse
//     net_ready, net_number network completion pulse and prediction
//     busy, done        batch in progress / one-cycle end-of-batch pulse
//     img_idx           images completed in the current batch
//     correct_cnt       correct predictions in the current batch
//     last_pred         low 4 bits of the latest prediction
//     err_timeout       sticky watchdog flag (0 when the watchdog is compiled out)
module tcb_batch_sequencer #(
    parameter int IMG_W   = 968,
    parameter int ADDR_W  = 10,
    parameter int PRED_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_img,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IMG_W-1:0]  mem_img,
    input  logic [3:0]        mem_label,
    output logic [IMG_W-1:0]  net_img,
    output logic              net_valid,
    input  logic              net_ready,
    input  logic [PRED_W-1:0] net_number,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   img_idx,
    output logic [ADDR_W:0]   correct_cnt,
    output logic [3:0]        last_pred,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_LAUNCH,
        S_WAIT_NET,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [ADDR_W:0] num_lat;
    logic [3:0]      label_q;

    // The full prediction word is compared, so any prediction above 9 can
    // never match a 4-bit label.
    function automatic logic pred_match(input logic [PRED_W-1:0] pred,
                                        input logic [3:0]        lbl);
        return pred == {{(PRED_W-4){1'b0}}, lbl};
    endfunction

`ifdef TCB_SEQ_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
    logic [WD_W-1:0] wd_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            net_img     <= '0;
            net_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            img_idx     <= '0;
            correct_cnt <= '0;
            last_pred   <= '0;
            num_lat     <= '0;
            label_q     <= '0;
`ifdef TCB_SEQ_WATCHDOG_EN
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            mem_rd    <= 1'b0;
            net_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_idx     <= '0;
                        correct_cnt <= '0;
                        last_pred   <= '0;
`ifdef TCB_SEQ_WATCHDOG_EN
                        err_timeout <= 1'b0;
`endif
                        if (num_img != '0) begin
                            num_lat  <= num_img;
                            busy     <= 1'b1;
                            mem_addr <= '0;
                            mem_rd   <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            // Empty batch: finish at once, never go busy.
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    net_img   <= mem_img;
                    label_q   <= mem_label;
                    net_valid <= 1'b1;
                    state     <= S_LAUNCH;
                end
                S_LAUNCH: begin
`ifdef TCB_SEQ_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT_NET;
                end
                S_WAIT_NET: begin
                    if (net_ready) begin
                        last_pred <= net_number[3:0];
                        if (pred_match(net_number, label_q)) begin
                            correct_cnt <= correct_cnt + CNT_ONE;
                        end
                        img_idx <= img_idx + CNT_ONE;
                        state   <= S_CHECK;
                    end
`ifdef TCB_SEQ_WATCHDOG_EN
                    // A silent network scores the image as wrong and moves on,
                    // leaving last_pred untouched.
                    else if (wd_cnt == WD_LAST) begin
                        err_timeout <= 1'b1;
                        img_idx     <= img_idx + CNT_ONE;
                        state       <= S_CHECK;
                    end else begin
                        wd_cnt <= wd_cnt + WD_ONE;
                    end
`endif
                end
                S_CHECK: begin
                    if (img_idx == num_lat) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                        mem_rd   <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcb_batch_sequencer.sv
`timescale 1ns/1ps
module tb_tcb_batch_sequencer;

    localparam int IMG_W   = 968;
    localparam int ADDR_W  = 10;
    localparam int PRED_W  = 32;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_img = '0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [IMG_W-1:0]  mem_img = '0;
    logic [3:0]        mem_label = '0;
    logic [IMG_W-1:0]  net_img;
    logic              net_valid;
    logic              net_ready;
    logic [PRED_W-1:0] net_number;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   img_idx;
    logic [ADDR_W:0]   correct_cnt;
    logic [3:0]        last_pred;
    logic              err_timeout;

    logic              nm_ready = 1'b0;
    logic [PRED_W-1:0] nm_number = '0;
    logic              spur_ready = 1'b0;
    logic [PRED_W-1:0] spur_number = '0;

    assign net_ready  = nm_ready | spur_ready;
    assign net_number = spur_ready ? spur_number : nm_number;

    int n_vec = 0;
    int n_bad = 0;

    tcb_batch_sequencer #(
        .IMG_W(IMG_W), .ADDR_W(ADDR_W), .PRED_W(PRED_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_img(num_img),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_img(mem_img),
        .mem_label(mem_label), .net_img(net_img), .net_valid(net_valid),
        .net_ready(net_ready), .net_number(net_number), .busy(busy),
        .done(done), .img_idx(img_idx), .correct_cnt(correct_cnt),
        .last_pred(last_pred), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Label table: addr 0..3 -> 7, 0, 3, 6
    function automatic logic [3:0] lbl_of(input int a);
        return 4'((3 * a + 7) % 10);
    endfunction

    // Network answer modes: 0 = label, 1 = (label+1)%10, 2 = silent, 3 = label+16
    int nm_mode [16];
    int nm_delay = 20;
    int nm_cnt = 0;
    logic nm_pend = 1'b0;
    int nm_addr = 0;

    function automatic int mode_of(input int a);
        if (a >= 0 && a < 16) return nm_mode[a];
        return 0;
    endfunction

    function automatic logic [PRED_W-1:0] answer(input int mode, input logic [3:0] l);
        case (mode)
            1:       return PRED_W'((int'(l) + 1) % 10);
            3:       return PRED_W'(int'(l) + 16);
            default: return PRED_W'(l);
        endcase
    endfunction

    // Synchronous image memory: each byte of the image is addr+0x11; data is
    // only meaningful in the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_img   <= {(IMG_W/8){8'(mem_addr) + 8'h11}};
            mem_label <= lbl_of(int'(mem_addr));
        end else begin
            mem_img   <= '1;
            mem_label <= 4'hF;
        end
    end

    // Network model: identifies the image from its pixel byte and answers
    // after nm_delay cycles according to its mode.
    always @(posedge clk) begin
        nm_ready <= 1'b0;
        if (net_valid) begin
            nm_pend <= 1'b1;
            nm_cnt  <= nm_delay;
            nm_addr <= int'(net_img[7:0]) - 'h11;
        end else if (nm_pend) begin
            if (nm_cnt <= 1) begin
                nm_pend <= 1'b0;
                if (mode_of(nm_addr) != 2) begin
                    nm_ready  <= 1'b1;
                    nm_number <= answer(mode_of(nm_addr), lbl_of(nm_addr));
                end
            end else begin
                nm_cnt <= nm_cnt - 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int r_first_nv, r_nv_cnt, r_done_k, r_done_cnt, r_last_rdy_k;
    int r_err_k, r_launch_k;
    bit r_busy_ok, r_busy_seen, r_busy_at_done;
    int r_addr [$];

    // k counts falling edges after the falling edge that raised start.
    task automatic run_batch(input int n, input bit inj);
        int k;
        bit injected;
        r_first_nv = -1; r_nv_cnt = 0; r_done_k = -1; r_done_cnt = 0;
        r_last_rdy_k = -1; r_err_k = -1; r_launch_k = -1;
        r_busy_ok = 1'b1; r_busy_seen = 1'b0; r_busy_at_done = 1'b1;
        r_addr.delete();
        injected = 1'b0;
        @(negedge clk);
        start = 1'b1;
        num_img = (ADDR_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 3000) begin
            if (net_valid) begin
                if (r_first_nv < 0) r_first_nv = k;
                r_nv_cnt++;
                r_addr.push_back(int'(mem_addr));
                r_launch_k = k;
            end
            if (net_ready) r_last_rdy_k = k;
            if (err_timeout && r_err_k < 0) r_err_k = k;
            if (busy) r_busy_seen = 1'b1;
            if (done) begin
                r_done_cnt++;
                if (r_done_k < 0) begin
                    r_done_k = k;
                    r_busy_at_done = busy;
                end
            end
            if (r_done_k < 0 && !busy) r_busy_ok = 1'b0;
            if (inj && !injected && mem_rd && r_nv_cnt == 1) begin
                start       = 1'b1;
                num_img     = (ADDR_W+1)'(1);
                spur_ready  = 1'b1;
                spur_number = PRED_W'(lbl_of(1));
                injected    = 1'b1;
            end
            if (r_done_k >= 0 && k >= r_done_k + 3) break;
            @(negedge clk);
            k++;
            start      = 1'b0;
            spur_ready = 1'b0;
        end
        check_val("batch_finished", 64'(r_done_k >= 0), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt, k, dn;
        logic [IMG_W-1:0] exp_img;
        for (int i = 0; i < 16; i++) nm_mode[i] = 0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check_val("rst_ctrl", {busy, done, mem_rd, net_valid, err_timeout}, 5'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_ctrl", {busy, done, mem_rd, net_valid, err_timeout}, 5'b0);
        check_val("idle_cnt", {img_idx, correct_cnt, last_pred, mem_addr}, '0);
        check_val("idle_img", 64'(net_img != '0), 64'd0);

        // Empty batch
        run_batch(0, 1'b0);
        check_val("n0_done_k", r_done_k, 1);
        check_val("n0_done_w", r_done_cnt, 1);
        check_val("n0_busy", r_busy_seen, 0);
        check_val("n0_nv", r_nv_cnt, 0);
        check_val("n0_corr", correct_cnt, 0);

        // Three images, all answered correctly
        run_batch(3, 1'b0);
        check_val("b3_first_nv", r_first_nv, 3);
        check_val("b3_nv", r_nv_cnt, 3);
        check_val("b3_addr", {r_addr[0][7:0], r_addr[1][7:0], r_addr[2][7:0]}, 24'h000102);
        check_val("b3_corr", correct_cnt, 3);
        check_val("b3_idx", img_idx, 3);
        check_val("b3_last", last_pred, 3);
        check_val("b3_done_w", r_done_cnt, 1);
        check_val("b3_busy", {r_busy_ok, r_busy_at_done}, 2'b10);
        check_val("b3_rdy_done", r_done_k - r_last_rdy_k, 2);
        exp_img = {(IMG_W/8){8'h13}};
        check_val("b3_img_hold", 64'(net_img == exp_img), 64'd1);

        // Empty batch clears the held counters
        run_batch(0, 1'b0);
        check_val("n0b_clear", {img_idx, correct_cnt, last_pred}, '0);
        check_val("n0b_done_k", r_done_k, 1);

        // Alternate right/wrong answers
        nm_mode[1] = 1;
        nm_mode[3] = 1;
        run_batch(4, 1'b0);
        check_val("b4_corr", correct_cnt, 2);
        check_val("b4_idx", img_idx, 4);
        check_val("b4_last", last_pred, 7);
        check_val("b4_nv", r_nv_cnt, 4);

        // Same batch with a stray start and stray ready during a fetch
        run_batch(4, 1'b1);
        check_val("inj_corr", correct_cnt, 2);
        check_val("inj_idx", img_idx, 4);
        check_val("inj_last", last_pred, 7);
        check_val("inj_nv", r_nv_cnt, 4);
        check_val("inj_addr3", r_addr.size() == 4 ? r_addr[3] : -1, 3);

        // Prediction above 9 with matching low bits is wrong
        for (int i = 0; i < 16; i++) nm_mode[i] = 0;
        nm_mode[0] = 3;
        run_batch(1, 1'b0);
        check_val("big_corr", correct_cnt, 0);
        check_val("big_last", last_pred, 7);

        // Reset during the wait for image 2
        nm_mode[0] = 0;
        @(negedge clk);
        start = 1'b1;
        num_img = (ADDR_W+1)'(4);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        k = 0;
        while (cnt < 3 && k < 500) begin
            if (net_valid) cnt++;
            @(negedge clk);
            k++;
        end
        check_val("abort_reach", cnt, 3);
        repeat (4) @(negedge clk);
        check_val("abort_pre", {busy, img_idx, correct_cnt}, {1'b1, 11'd2, 11'd2});
        #2 rst = 1'b0;
        #1;
        check_val("abort_async", {busy, img_idx, correct_cnt, last_pred, mem_addr}, '0);
        check_val("abort_img", 64'(net_img != '0), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check_val("abort_quiet", dn, 0);
        check_val("abort_hold", {img_idx, correct_cnt, last_pred}, '0);
        run_batch(1, 1'b0);
        check_val("after_corr", correct_cnt, 1);
        check_val("after_idx", img_idx, 1);
        check_val("after_last", last_pred, 7);

`ifdef TCB_SEQ_WATCHDOG_EN
        // Silent network on image 1 of 2
        nm_mode[1] = 2;
        run_batch(2, 1'b0);
        check_val("wd_err", err_timeout, 1);
        check_val("wd_err_k", r_err_k - r_launch_k, 65);
        check_val("wd_idx", img_idx, 2);
        check_val("wd_corr", correct_cnt, 1);
        check_val("wd_last", last_pred, 7);
        nm_mode[1] = 0;
        run_batch(0, 1'b0);
        check_val("wd_clear", err_timeout, 0);
`else
        check_val("no_wd_err", err_timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
